// File: rtl/ascon_arbiter.sv
// Round-robin arbiter that lends a single ascon_core to one of NREQ requesters for a whole
// operation (issue -> core done) and routes the key/bdi/bdo/auth streams to the current owner.
module ascon_arbiter #(
    parameter int CCW  = 32,
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // requester side: mode / completion
    input  logic [NREQ*4-1:0]     req_mode_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [NREQ-1:0]       req_done_o,
    output logic [NREQ-1:0]       req_auth_o,
    // requester side: key stream
    input  logic [NREQ*CCW-1:0]   req_key_i,
    input  logic [NREQ-1:0]       req_key_valid_i,
    output logic [NREQ-1:0]       req_key_ready_o,
    // requester side: bdi stream
    input  logic [NREQ*CCW-1:0]   req_bdi_i,
    input  logic [NREQ*CCW/8-1:0] req_bdi_valid_i,
    input  logic [NREQ*4-1:0]     req_bdi_type_i,
    input  logic [NREQ-1:0]       req_bdi_eot_i,
    input  logic [NREQ-1:0]       req_bdi_eoi_i,
    output logic [NREQ-1:0]       req_bdi_ready_o,
    // requester side: bdo stream
    output logic [NREQ*CCW-1:0]   req_bdo_o,
    output logic [NREQ-1:0]       req_bdo_valid_o,
    output logic [NREQ*4-1:0]     req_bdo_type_o,
    output logic [NREQ-1:0]       req_bdo_eot_o,
    input  logic [NREQ-1:0]       req_bdo_ready_i,
    input  logic [NREQ-1:0]       req_bdo_eoo_i,
    // ownership
    output logic [NREQ-1:0]       grant_o,
    // core side
    output logic [3:0]            core_mode_o,
    output logic [CCW-1:0]        core_key_o,
    output logic                  core_key_valid_o,
    input  logic                  core_key_ready_i,
    output logic [CCW-1:0]        core_bdi_o,
    output logic [CCW/8-1:0]      core_bdi_valid_o,
    output logic [3:0]            core_bdi_type_o,
    output logic                  core_bdi_eot_o,
    output logic                  core_bdi_eoi_o,
    input  logic                  core_bdi_ready_i,
    input  logic [CCW-1:0]        core_bdo_i,
    input  logic                  core_bdo_valid_i,
    input  logic [3:0]            core_bdo_type_i,
    input  logic                  core_bdo_eot_i,
    output logic                  core_bdo_ready_o,
    output logic                  core_bdo_eoo_o,
    input  logic                  core_auth_i,
    input  logic                  core_auth_valid_i,
    input  logic                  core_done_i,
    output logic                  core_rst_o
);

    localparam int         BW     = CCW / 8;
    localparam int         IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] M_CXOF = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RELEASE
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] req_ready_q;
    logic [NREQ-1:0] req_done_q;
    logic [NREQ-1:0] req_auth_q;
    logic [3:0]      core_mode_q;
    logic [1:0]      rst_sync_q;

    logic [NREQ-1:0] pending;
    logic            any_pending;
    logic [IW-1:0]   winner_d;
    logic            mode_ok;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

    // Core reset asserts with rst_n and releases two clocks after it, so the core leaves reset cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign core_rst_o = rst_sync_q[1];

    // Round-robin search: first pending requester at or after rr_ptr_q, wrapping.
    always_comb begin
        logic found;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        pending  = '0;
        winner_d = '0;
        found    = 1'b0;
        mode_ok  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pending[i] = |req_mode_i[i*4 +: 4];
            if (req_mode_i[i*4 +: 4] > M_CXOF) begin
                mode_ok = 1'b0;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && pending[(int'(rr_ptr_q) + k) % NREQ]) begin
                found    = 1'b1;
                winner_d = IW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    assign any_pending = |pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_auth_q  <= '0;
            core_mode_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_auth_q  <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (!core_rst_o && any_pending) begin
                        owner_q     <= winner_d;
                        grant_q     <= onehot(winner_d);
                        req_ready_q <= onehot(winner_d);
                        core_mode_q <= req_mode_i[int'(winner_d)*4 +: 4];
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // core_done may still be high from the previous operation; it is only trusted in BUSY.
                    core_mode_q <= '0;
                    state_q     <= S_BUSY;
                end
                S_BUSY: begin
                    if (core_done_i) begin
                        req_done_q <= onehot(owner_q);
                        req_auth_q <= onehot(owner_q) & {NREQ{core_auth_i & core_auth_valid_i}};
                        state_q    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    grant_q  <= '0;
                    rr_ptr_q <= (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign req_ready_o = req_ready_q;
    assign req_done_o  = req_done_q;
    assign req_auth_o  = req_auth_q;
    assign core_mode_o = core_mode_q;

    // Zero-latency stream routing selected by grant only; with no owner every valid/ready is 0.
    always_comb begin
        core_key_o       = '0;
        core_key_valid_o = 1'b0;
        core_bdi_o       = '0;
        core_bdi_valid_o = '0;
        core_bdi_type_o  = '0;
        core_bdi_eot_o   = 1'b0;
        core_bdi_eoi_o   = 1'b0;
        core_bdo_ready_o = 1'b0;
        core_bdo_eoo_o   = 1'b0;
        req_key_ready_o  = '0;
        req_bdi_ready_o  = '0;
        req_bdo_o        = '0;
        req_bdo_valid_o  = '0;
        req_bdo_type_o   = '0;
        req_bdo_eot_o    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                core_key_o                 = req_key_i[i*CCW +: CCW];
                core_key_valid_o           = req_key_valid_i[i];
                core_bdi_o                 = req_bdi_i[i*CCW +: CCW];
                core_bdi_valid_o           = req_bdi_valid_i[i*BW +: BW];
                core_bdi_type_o            = req_bdi_type_i[i*4 +: 4];
                core_bdi_eot_o             = req_bdi_eot_i[i];
                core_bdi_eoi_o             = req_bdi_eoi_i[i];
                core_bdo_ready_o           = req_bdo_ready_i[i];
                core_bdo_eoo_o             = req_bdo_eoo_i[i];
                req_key_ready_o[i]         = core_key_ready_i;
                req_bdi_ready_o[i]         = core_bdi_ready_i;
                req_bdo_o[i*CCW +: CCW]    = core_bdo_i;
                req_bdo_valid_o[i]         = core_bdo_valid_i;
                req_bdo_type_o[i*4 +: 4]   = core_bdo_type_i;
                req_bdo_eot_o[i]           = core_bdo_eot_i;
            end
        end
    end

    // A mode above M_CXOF is never completed by the core and would hang the arbiter in BUSY.
    a_mode_valid : assert property (@(posedge clk) disable iff (!rst_n) mode_ok);

endmodule
